// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for a 5-stage in-order pipeline.
// Detects RAW hazards between the ID-stage sources and the EX/MEM writers.
// Holds the front end while a branch in ID waits for its outcome from EX, and
// squashes IF/ID for one cycle when the branch is taken.
// A saturating counter tracks cycles spent stalled. A sticky flag records any
// branch that never resolved within BR_LAT cycles.
module hazard_stall_ctrl #(
    parameter int REG_AW  = 5,
    parameter int HAS_FWD = 1,
    parameter int BR_LAT  = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_reg1,
    input  logic [REG_AW-1:0] id_reg2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_func,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              ex_wr,
    input  logic              mem_wr,
    input  logic              ex_load,
    input  logic              mem_load,
    input  logic              br_resolved,
    input  logic              br_taken,
    input  logic              cnt_clr,
    output logic              stall,
    output logic              flush,
    output logic              data_hazard,
    output logic              control_hazard,
    output logic              br_timeout,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_e;

    localparam logic [3:0] BR_LAT_V = 4'(BR_LAT);

    state_e            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              is_branch;
    logic              ex_match;
    logic              mem_match;
    logic              dh_now;

    // Conditional branches plus register jumps (jr/jalr) all need the EX outcome.
    assign is_branch = (id_opcode == 6'h01) || (id_opcode == 6'h04) ||
                       (id_opcode == 6'h05) || (id_opcode == 6'h06) ||
                       (id_opcode == 6'h07) ||
                       ((id_opcode == 6'h00) && ((id_func == 6'h08) || (id_func == 6'h09)));

    // Register 0 is hard-wired, so a write to it never creates a dependence.
    assign ex_match  = ex_wr && (ex_dest != '0) &&
                       ((id_use1 && (id_reg1 == ex_dest)) || (id_use2 && (id_reg2 == ex_dest)));
    assign mem_match = mem_wr && (mem_dest != '0) &&
                       ((id_use1 && (id_reg1 == mem_dest)) || (id_use2 && (id_reg2 == mem_dest)));

    // With forwarding only load results and branch operands read in ID must wait.
    assign dh_now = (HAS_FWD != 0) ?
                    ((ex_match && ex_load) || (is_branch && ex_match) ||
                     (is_branch && mem_match && mem_load)) :
                    (ex_match || mem_match);

    // Next-state logic: a data hazard always holds the FSM in IDLE first.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path infers a latch.
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (is_branch && !dh_now) begin
                    state_d = BR_WAIT;
                    wait_d  = BR_LAT_V;
                end
            end
            BR_WAIT: begin
                if (br_resolved) begin
                    state_d = br_taken ? FLUSH : IDLE;
                    wait_d  = '0;
                end else if (wait_q <= 4'd1) begin
                    state_d   = IDLE;
                    wait_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                wait_d  = '0;
            end
        endcase
    end

    // Combinational outputs, forced low while reset is held.
    always_comb begin
        // NOTE: dh_now and is_branch follow the inputs even in reset, so outputs are gated explicitly.
        stall          = reset && (((state_q == IDLE) && dh_now) || (state_q == BR_WAIT));
        flush          = reset && (state_q == FLUSH);
        data_hazard    = reset && (state_q == IDLE) && dh_now;
        control_hazard = reset && (((state_q == IDLE) && is_branch) ||
                                   (state_q == BR_WAIT) || (state_q == FLUSH));
    end

    // Stall counter: clear wins, otherwise count stalled cycles up to all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, wait counter, timeout flag and stall counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update together from pre-edge values.
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign br_timeout = timeout_q;
    assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: a table of single-cycle hazard vectors, then
// hand-written sequences for branch wait, flush, timeout, counter and reset.
// A forwarding instance (CNT_W=3) is the main target. A second instance without
// forwarding is compared only during the table, where both stay in IDLE.
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] id_reg1, id_reg2, ex_dest, mem_dest;
    logic       id_use1, id_use2;
    logic [5:0] id_opcode, id_func;
    logic       ex_wr, mem_wr, ex_load, mem_load;
    logic       br_resolved, br_taken, cnt_clr;

    logic       stall, flush, data_hazard, control_hazard, br_timeout;
    logic [2:0] stall_cnt;
    logic       nf_stall, nf_flush, nf_dh, nf_ch, nf_to;
    logic [2:0] nf_cnt;

    int n_checks = 0;
    int n_errors = 0;

    hazard_stall_ctrl #(.REG_AW(5), .HAS_FWD(1), .BR_LAT(2), .CNT_W(3)) u_dut (
        .clk(clk), .reset(reset),
        .id_reg1(id_reg1), .id_reg2(id_reg2), .id_use1(id_use1), .id_use2(id_use2),
        .id_opcode(id_opcode), .id_func(id_func),
        .ex_dest(ex_dest), .mem_dest(mem_dest),
        .ex_wr(ex_wr), .mem_wr(mem_wr), .ex_load(ex_load), .mem_load(mem_load),
        .br_resolved(br_resolved), .br_taken(br_taken), .cnt_clr(cnt_clr),
        .stall(stall), .flush(flush), .data_hazard(data_hazard),
        .control_hazard(control_hazard), .br_timeout(br_timeout), .stall_cnt(stall_cnt)
    );

    hazard_stall_ctrl #(.REG_AW(5), .HAS_FWD(0), .BR_LAT(2), .CNT_W(3)) u_nofwd (
        .clk(clk), .reset(reset),
        .id_reg1(id_reg1), .id_reg2(id_reg2), .id_use1(id_use1), .id_use2(id_use2),
        .id_opcode(id_opcode), .id_func(id_func),
        .ex_dest(ex_dest), .mem_dest(mem_dest),
        .ex_wr(ex_wr), .mem_wr(mem_wr), .ex_load(ex_load), .mem_load(mem_load),
        .br_resolved(br_resolved), .br_taken(br_taken), .cnt_clr(cnt_clr),
        .stall(nf_stall), .flush(nf_flush), .data_hazard(nf_dh),
        .control_hazard(nf_ch), .br_timeout(nf_to), .stall_cnt(nf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [4:0] reg1, reg2;
        logic       use1, use2;
        logic [5:0] op, fn;
        logic [4:0] exd, memd;
        logic       exwr, memwr, exld, memld;
    } in_t;

    typedef struct {
        in_t  in;
        logic stall, dh, ch, nf;
    } vec_t;

    typedef struct {
        string name;
        logic  stall, flush, dh, ch, nf;
        bit    use_nf;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[15];

    function automatic vec_t mk(logic [4:0] r1, logic [4:0] r2, logic u1, logic u2,
                                logic [5:0] op, logic [5:0] fn, logic [4:0] exd,
                                logic [4:0] memd, logic exwr, logic memwr,
                                logic exld, logic memld,
                                logic s, logic d, logic c, logic nf);
        vec_t v;
        v.in = '{reg1: r1, reg2: r2, use1: u1, use2: u2, op: op, fn: fn,
                 exd: exd, memd: memd, exwr: exwr, memwr: memwr, exld: exld, memld: memld};
        v.stall = s;
        v.dh    = d;
        v.ch    = c;
        v.nf    = nf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_in(input in_t v);
        id_reg1 = v.reg1; id_reg2 = v.reg2; id_use1 = v.use1; id_use2 = v.use2;
        id_opcode = v.op; id_func = v.fn; ex_dest = v.exd; mem_dest = v.memd;
        ex_wr = v.exwr; mem_wr = v.memwr; ex_load = v.exld; mem_load = v.memld;
    endtask

    task automatic clear_in();
        apply_in('{reg1: 5'd0, reg2: 5'd0, use1: 1'b0, use2: 1'b0, op: 6'h00, fn: 6'h20,
                   exd: 5'd0, memd: 5'd0, exwr: 1'b0, memwr: 1'b0, exld: 1'b0, memld: 1'b0});
        br_resolved = 1'b0;
        br_taken    = 1'b0;
    endtask

    task automatic push(input string n, input logic s, input logic f, input logic d,
                        input logic c, input logic nf, input bit use_nf);
        exp_t e;
        e.name = n; e.stall = s; e.flush = f; e.dh = d; e.ch = c; e.nf = nf; e.use_nf = use_nf;
        sb_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare against the outputs sampled now.
    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check({e.name, ".stall"}, stall, e.stall);
        check({e.name, ".flush"}, flush, e.flush);
        check({e.name, ".data_hazard"}, data_hazard, e.dh);
        check({e.name, ".control_hazard"}, control_hazard, e.ch);
        if (e.use_nf) check({e.name, ".nofwd_stall"}, nf_stall, e.nf);
    endtask

    // Expect outputs for the current cycle, sampled on the falling edge.
    task automatic sb_cycle(input string n, input logic s, input logic f,
                            input logic d, input logic c);
        push(n, s, f, d, c, 1'b0, 1'b0);
        @(negedge clk);
        pop_check();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        clear_in();
        cnt_clr = 1'b0;
        reset   = 1'b0;
        #3;
        reset   = 1'b1;
    endtask

    task automatic drive_branch_clean();
        clear_in();
        id_opcode = 6'h04;
        id_reg1   = 5'd3;
        id_use1   = 1'b1;
    endtask

    initial begin
        //        r1 r2 u1 u2 op     fn     exd memd exwr memwr exld memld  s  d  c  nf
        tbl[0]  = mk(5, 3, 1, 0, 6'h00, 6'h20, 5, 0, 1, 0, 1, 0, 1, 1, 0, 1); // load-use
        tbl[1]  = mk(5, 3, 1, 0, 6'h00, 6'h20, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1); // ALU, forwarded
        tbl[2]  = mk(0, 0, 1, 1, 6'h00, 6'h20, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0); // dest 0
        tbl[3]  = mk(1, 7, 0, 1, 6'h00, 6'h20, 0, 7, 0, 1, 0, 0, 0, 0, 0, 1); // MEM ALU match
        tbl[4]  = mk(5, 3, 0, 1, 6'h00, 6'h20, 5, 0, 1, 0, 1, 0, 0, 0, 0, 0); // source unused
        tbl[5]  = mk(5, 3, 1, 0, 6'h00, 6'h20, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0); // writer invalid
        tbl[6]  = mk(0, 8, 0, 1, 6'h04, 6'h00, 8, 0, 1, 0, 0, 0, 1, 1, 1, 1); // beq, EX ALU
        tbl[7]  = mk(9, 0, 1, 0, 6'h05, 6'h00, 0, 9, 0, 1, 0, 1, 1, 1, 1, 1); // bne, MEM load
        tbl[8]  = mk(4, 0, 1, 0, 6'h00, 6'h08, 4, 0, 1, 0, 0, 0, 1, 1, 1, 1); // jr, EX ALU
        tbl[9]  = mk(9, 0, 1, 0, 6'h00, 6'h20, 0, 9, 0, 1, 0, 1, 0, 0, 0, 1); // add, MEM load
        tbl[10] = mk(2, 0, 1, 0, 6'h23, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // no writers
        tbl[11] = mk(4, 0, 1, 0, 6'h00, 6'h09, 4, 0, 1, 0, 0, 0, 1, 1, 1, 1); // jalr
        tbl[12] = mk(4, 0, 1, 0, 6'h00, 6'h0a, 4, 0, 1, 0, 0, 0, 0, 0, 0, 1); // func 0x0a no branch
        tbl[13] = mk(6, 0, 1, 0, 6'h07, 6'h00, 0, 6, 0, 1, 0, 1, 1, 1, 1, 1); // bgtz, MEM load
        tbl[14] = mk(6, 0, 1, 0, 6'h02, 6'h00, 6, 0, 1, 0, 0, 0, 0, 0, 0, 1); // j is not a branch

        // Reset held with a load-use hazard on the inputs: everything stays low.
        clear_in();
        cnt_clr = 1'b0;
        reset   = 1'b0;
        apply_in(tbl[0].in);
        push("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        pop_check();
        check("reset.stall_cnt", stall_cnt, 3'd0);
        check("reset.br_timeout", br_timeout, 1'b0);
        next_cycle();
        reset = 1'b1;

        // Single-cycle hazard table; the counter is held clear throughout.
        cnt_clr = 1'b1;
        for (int i = 0; i < 15; i++) begin
            next_cycle();
            apply_in(tbl[i].in);
            push($sformatf("vec%0d", i), tbl[i].stall, 1'b0, tbl[i].dh, tbl[i].ch, tbl[i].nf, 1'b1);
            @(negedge clk);
            pop_check();
        end
        check("table.stall_cnt_cleared", stall_cnt, 3'd0);

        // Branch held by an EX operand hazard, then wait and taken flush.
        do_reset();
        next_cycle();
        clear_in();
        id_opcode = 6'h04; id_reg2 = 5'd8; id_use2 = 1'b1; ex_dest = 5'd8; ex_wr = 1'b1;
        sb_cycle("beq_ex_hazard", 1'b1, 1'b0, 1'b1, 1'b1);
        next_cycle();
        ex_wr = 1'b0;
        sb_cycle("beq_ex_clear", 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        clear_in();
        sb_cycle("br_wait", 1'b1, 1'b0, 1'b0, 1'b1);
        next_cycle();
        br_resolved = 1'b1; br_taken = 1'b1;
        sb_cycle("br_wait_taken", 1'b1, 1'b0, 1'b0, 1'b1);
        next_cycle();
        br_resolved = 1'b0; br_taken = 1'b0;
        sb_cycle("flush", 1'b0, 1'b1, 1'b0, 1'b1);
        next_cycle();
        sb_cycle("after_flush", 1'b0, 1'b0, 1'b0, 1'b0);

        // Not-taken resolution returns to IDLE with no flush.
        next_cycle();
        drive_branch_clean();
        sb_cycle("beq_clean", 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        clear_in();
        br_resolved = 1'b1; br_taken = 1'b0;
        sb_cycle("br_wait_not_taken", 1'b1, 1'b0, 1'b0, 1'b1);
        next_cycle();
        br_resolved = 1'b0;
        sb_cycle("not_taken_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        check("not_taken.br_timeout", br_timeout, 1'b0);

        // Unresolved branch: two wait cycles, then timeout which stays set.
        do_reset();
        next_cycle();
        drive_branch_clean();
        sb_cycle("to_enter", 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        clear_in();
        sb_cycle("to_wait1", 1'b1, 1'b0, 1'b0, 1'b1);
        check("to_wait1.br_timeout", br_timeout, 1'b0);
        next_cycle();
        sb_cycle("to_wait2", 1'b1, 1'b0, 1'b0, 1'b1);
        next_cycle();
        sb_cycle("to_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        check("to_idle.br_timeout", br_timeout, 1'b1);
        check("to_idle.stall_cnt", stall_cnt, 3'd2);
        next_cycle();
        br_resolved = 1'b1; br_taken = 1'b1;
        sb_cycle("resolve_in_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        br_resolved = 1'b0; br_taken = 1'b0;
        sb_cycle("no_flush_from_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        check("timeout_sticky", br_timeout, 1'b1);
        do_reset();
        #1;
        check("timeout_cleared_by_reset", br_timeout, 1'b0);

        // Stall counter: count, saturate at 7, clear wins over increment.
        next_cycle();
        apply_in(tbl[0].in);
        repeat (4) @(posedge clk);
        #1;
        check("cnt_four", stall_cnt, 3'd4);
        repeat (6) @(posedge clk);
        #1;
        check("cnt_saturated", stall_cnt, 3'd7);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        check("cnt_clr_with_stall", stall_cnt, 3'd0);
        check("cnt_clr.stall", stall, 1'b1);
        cnt_clr = 1'b0;

        // Reset in BR_WAIT with the counter at 7 aborts everything at once.
        repeat (7) @(posedge clk);
        #1;
        check("cnt_seven", stall_cnt, 3'd7);
        drive_branch_clean();
        next_cycle();
        clear_in();
        check("pre_reset.stall_in_br_wait", stall, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_wait_reset.stall", stall, 1'b0);
        check("mid_wait_reset.stall_cnt", stall_cnt, 3'd0);
        check("mid_wait_reset.control_hazard", control_hazard, 1'b0);
        reset = 1'b1;
        next_cycle();
        sb_cycle("after_wait_reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in FLUSH: pulse drops at once and does not reappear.
        next_cycle();
        drive_branch_clean();
        sb_cycle("fl_enter", 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        clear_in();
        br_resolved = 1'b1; br_taken = 1'b1;
        sb_cycle("fl_wait", 1'b1, 1'b0, 1'b0, 1'b1);
        next_cycle();
        br_resolved = 1'b0; br_taken = 1'b0;
        check("pre_reset.flush", flush, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_flush_reset.flush", flush, 1'b0);
        reset = 1'b1;
        next_cycle();
        sb_cycle("after_flush_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        sb_cycle("after_flush_reset2", 1'b0, 1'b0, 1'b0, 1'b0);

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
